// File: rtl/isa_pkg.sv
// Shared ISA definitions: instruction width, NOP encoding and the
// instruction-memory controller states.
package isa_pkg;

    localparam int INSTR_W = 9;

    typedef logic [INSTR_W-1:0] instr_t;

    localparam instr_t NOP = '0;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } imem_state_e;

endpackage

// File: rtl/imem_bank_ram.sv
// One program bank: DEPTH x IW synchronous RAM with one write port and one
// registered read port.
module imem_bank_ram #(
    parameter int IW    = 9,
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [IW-1:0] wr_data,
    input  logic          re,
    input  logic [AW-1:0] rd_addr,
    output logic [IW-1:0] rd_data
);

    logic [IW-1:0] mem [DEPTH];

    // Read data only moves when re is high, so it holds through stalls and idle cycles.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/inst_mem_banked.sv
// Banked, loadable instruction memory: NBANK program RAMs, a sequential
// loader, registered 1-cycle fetch and a sticky fault flag.
module inst_mem_banked
    import isa_pkg::*;
#(
    parameter int IW    = INSTR_W,
    parameter int PCW   = 8,
    parameter int DEPTH = 256,
    parameter int NBANK = 4,
    localparam int BW   = (NBANK > 1) ? $clog2(NBANK) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [BW-1:0]  bank_sel,
    input  logic [PCW-1:0] prog_ctr,
    input  logic           fetch_en,
    input  logic           stall,
    output logic [IW-1:0]  mach_code,
    output logic           code_valid,
    output logic           fault,
    input  logic           load_start,
    input  logic [BW-1:0]  load_bank,
    input  logic           load_we,
    input  logic [IW-1:0]  load_data,
    input  logic           load_done,
    output logic           loading
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  CNT_FULL   = CW'(DEPTH);
    localparam logic [PCW:0]   PC_LIMIT   = (PCW + 1)'(DEPTH);
    localparam logic [BW:0]    BANK_LIMIT = (BW + 1)'(NBANK);

    imem_state_e   state;
    logic [CW-1:0] cnt;
    logic [BW-1:0] wr_bank;
    logic [BW-1:0] rd_bank;
    logic          nop_q;
    logic [IW-1:0] rd_data [NBANK];
    logic          fetch_go;
    logic          in_range;
    logic          write_go;

    assign fetch_go = (state == RUN) && fetch_en && !stall && !load_start;
    assign in_range = ({1'b0, prog_ctr} < PC_LIMIT) && ({1'b0, bank_sel} < BANK_LIMIT);
    assign write_go = (state == LOAD) && load_we && !load_start && (cnt != CNT_FULL);

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        imem_bank_ram #(
            .IW    (IW),
            .AW    (AW),
            .DEPTH (DEPTH)
        ) u_ram (
            .clk     (clk),
            .we      (write_go && (wr_bank == BW'(b))),
            .wr_addr (cnt[AW-1:0]),
            .wr_data (load_data),
            .re      (fetch_go && in_range && (bank_sel == BW'(b))),
            .rd_addr (prog_ctr[AW-1:0]),
            .rd_data (rd_data[b])
        );
    end

    // load_start takes priority over everything, including a simultaneous load_done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_bank    <= '0;
            rd_bank    <= '0;
            nop_q      <= 1'b1;
            code_valid <= 1'b0;
            fault      <= 1'b0;
            loading    <= 1'b0;
        end else if (load_start) begin
            state      <= LOAD;
            cnt        <= '0;
            wr_bank    <= load_bank;
            nop_q      <= 1'b1;
            code_valid <= 1'b0;
            loading    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_en) begin
                        state <= RUN;
                    end
                end
                LOAD: begin
                    if (load_we) begin
                        if (cnt == CNT_FULL) begin
                            fault <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    if (load_done) begin
                        state   <= RUN;
                        loading <= 1'b0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (fetch_en) begin
                            rd_bank    <= bank_sel;
                            code_valid <= 1'b1;
                            nop_q      <= !in_range;
                            if (!in_range) begin
                                fault <= 1'b1;
                            end
                        end else begin
                            code_valid <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output mux only sees registered state, so prog_ctr never reaches mach_code combinationally.
    always_comb begin
        mach_code = IW'(NOP);
        if (!nop_q) begin
            for (int b = 0; b < NBANK; b++) begin
                if (rd_bank == BW'(b)) begin
                    mach_code = rd_data[b];
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_mem_banked.sv
// Self-checking bench for inst_mem_banked: a full-size instance and a
// DEPTH=4 / NBANK=3 instance share stimulus and are checked against array models.
module tb_inst_mem_banked;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] bank_sel;
    logic [7:0] prog_ctr;
    logic       fetch_en;
    logic       stall;
    logic       load_start;
    logic [1:0] load_bank;
    logic       load_we;
    logic [8:0] load_data;
    logic       load_done;

    logic [8:0] code_b, code_s;
    logic       valid_b, valid_s;
    logic       fault_b, fault_s;
    logic       loading_b, loading_s;

    int total = 0;
    int bad   = 0;

    // Behavioural model: memory images with "known" flags, loader counters, faults, expected outputs.
    logic [8:0] mb [4][256];
    bit         kb [4][256];
    logic [8:0] ms [3][4];
    bit         ks [3][4];
    int         cnt_b, cnt_s;
    bit         f_b, f_s;
    logic [8:0] e_code_b, e_code_s;
    bit         e_kb, e_ks;
    bit         e_valid;
    logic [8:0] load_q [$];

    always #5 clk = ~clk;

    inst_mem_banked dut_big (
        .clk(clk), .reset(reset), .bank_sel(bank_sel), .prog_ctr(prog_ctr),
        .fetch_en(fetch_en), .stall(stall), .mach_code(code_b), .code_valid(valid_b),
        .fault(fault_b), .load_start(load_start), .load_bank(load_bank), .load_we(load_we),
        .load_data(load_data), .load_done(load_done), .loading(loading_b)
    );

    inst_mem_banked #(.IW(9), .PCW(8), .DEPTH(4), .NBANK(3)) dut_small (
        .clk(clk), .reset(reset), .bank_sel(bank_sel), .prog_ctr(prog_ctr),
        .fetch_en(fetch_en), .stall(stall), .mach_code(code_s), .code_valid(valid_s),
        .fault(fault_s), .load_start(load_start), .load_bank(load_bank), .load_we(load_we),
        .load_data(load_data), .load_done(load_done), .loading(loading_s)
    );

    task automatic model_reset();
        cnt_b = 0; cnt_s = 0; f_b = 0; f_s = 0;
        e_code_b = '0; e_code_s = '0; e_kb = 1; e_ks = 1; e_valid = 0;
    endtask

    task automatic model_load_start();
        cnt_b = 0; cnt_s = 0;
        e_code_b = '0; e_code_s = '0; e_kb = 1; e_ks = 1; e_valid = 0;
    endtask

    task automatic model_write(input int bank, input logic [8:0] w);
        if (cnt_b < 256) begin
            mb[bank][cnt_b] = w; kb[bank][cnt_b] = 1; cnt_b++;
        end else begin
            f_b = 1;
        end
        if (cnt_s < 4) begin
            if (bank < 3) begin
                ms[bank][cnt_s] = w; ks[bank][cnt_s] = 1;
            end
            cnt_s++;
        end else begin
            f_s = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [1:0] bank);
        fetch_en = 0; stall = 0;
        load_bank = bank; load_start = 1;
        tick();
        load_start = 0;
        model_load_start();
        foreach (load_q[i]) begin
            load_we = 1; load_data = load_q[i];
            tick();
            model_write(bank, load_q[i]);
        end
        load_we = 0; load_done = 1;
        tick();
        load_done = 0;
    endtask

    task automatic run_cycle(input bit fe, input bit st, input logic [1:0] bank, input logic [7:0] pc);
        fetch_en = fe; stall = st; bank_sel = bank; prog_ctr = pc;
        tick();
        if (!st) begin
            if (fe) begin
                e_valid  = 1;
                e_code_b = mb[bank][pc];
                e_kb     = kb[bank][pc];
                if (pc < 4 && bank < 3) begin
                    e_code_s = ms[bank][pc[1:0]];
                    e_ks     = ks[bank][pc[1:0]];
                end else begin
                    e_code_s = '0; e_ks = 1; f_s = 1;
                end
            end else begin
                e_valid = 0;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1;
        #2;
        model_reset();
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        #2;
        model_reset();
        total++;
        if ({code_b, valid_b, fault_b, loading_b} !== 12'h000) begin
            bad++; $display("[TB] FAIL reset_big: got %h want 000", {code_b, valid_b, fault_b, loading_b});
        end
        total++;
        if ({code_s, valid_s, fault_s, loading_s} !== 12'h000) begin
            bad++; $display("[TB] FAIL reset_small: got %h want 000", {code_s, valid_s, fault_s, loading_s});
        end
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_basic_fetch();
        logic [8:0] want [3];
        want[0] = 9'h19C; want[1] = 9'h1A3; want[2] = 9'h19D;
        load_q = '{9'h19C, 9'h1A3, 9'h19D};
        for (int i = 0; i < 5; i++) load_q.push_back(9'($urandom));
        do_load(2'd0);
        total++;
        if (loading_b !== 1'b0 || valid_b !== 1'b0) begin
            bad++; $display("[TB] FAIL load_exit: got loading=%b valid=%b want 0 0", loading_b, valid_b);
        end
        for (int pc = 0; pc < 3; pc++) begin
            run_cycle(1, 0, 2'd0, 8'(pc));
            total++;
            if (code_b !== want[pc] || valid_b !== 1'b1) begin
                bad++; $display("[TB] FAIL basic_fetch pc%0d: got %h/%b want %h/1", pc, code_b, valid_b, want[pc]);
            end
        end
        run_cycle(0, 0, 2'd0, 8'd0);
        total++;
        if (valid_b !== 1'b0 || code_b !== 9'h19D) begin
            bad++; $display("[TB] FAIL idle_hold: got %h/%b want 19d/0", code_b, valid_b);
        end
    endtask

    task automatic test_bank_select();
        load_q = {};
        for (int i = 0; i < 5; i++) load_q.push_back(9'($urandom));
        load_q.push_back(9'h0AA);
        do_load(2'd1);
        run_cycle(1, 0, 2'd0, 8'd5);
        total++;
        if (code_b !== e_code_b || valid_b !== 1'b1) begin
            bad++; $display("[TB] FAIL bank0_pc5: got %h/%b want %h/1", code_b, valid_b, e_code_b);
        end
        run_cycle(1, 0, 2'd1, 8'd5);
        total++;
        if (code_b !== 9'h0AA) begin
            bad++; $display("[TB] FAIL bank1_pc5: got %h want 0aa", code_b);
        end
        run_cycle(1, 0, 2'd0, 8'd0);
        total++;
        if (code_b !== 9'h19C) begin
            bad++; $display("[TB] FAIL bank0_intact: got %h want 19c", code_b);
        end
    endtask

    task automatic test_stall();
        logic [8:0] held;
        run_cycle(1, 0, 2'd0, 8'd3);
        held = e_code_b;
        for (int i = 0; i < 3; i++) begin
            run_cycle(1, 1, 2'($urandom_range(0, 1)), 8'($urandom_range(0, 7)));
            total++;
            if (code_b !== held || valid_b !== 1'b1) begin
                bad++; $display("[TB] FAIL stall_hold%0d: got %h/%b want %h/1", i, code_b, valid_b, held);
            end
        end
        run_cycle(1, 0, 2'd1, 8'd5);
        total++;
        if (code_b !== 9'h0AA || valid_b !== 1'b1) begin
            bad++; $display("[TB] FAIL stall_release: got %h/%b want 0aa/1", code_b, valid_b);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        load_q = {};
        for (int i = 0; i < 5; i++) load_q.push_back(9'($urandom));
        do_load(2'd1);
        total++;
        if (fault_s !== 1'b1 || fault_b !== 1'b0) begin
            bad++; $display("[TB] FAIL overflow_fault: got small=%b big=%b want 1 0", fault_s, fault_b);
        end
        for (int pc = 0; pc < 4; pc++) begin
            run_cycle(1, 0, 2'd1, 8'(pc));
            total++;
            if (code_s !== load_q[pc]) begin
                bad++; $display("[TB] FAIL small_word%0d: got %h want %h", pc, code_s, load_q[pc]);
            end
        end
        run_cycle(1, 0, 2'd1, 8'd4);
        total++;
        if (code_s !== 9'h000 || valid_s !== 1'b1 || fault_s !== 1'b1) begin
            bad++; $display("[TB] FAIL small_oor_pc: got %h/%b/%b want 000/1/1", code_s, valid_s, fault_s);
        end
        total++;
        if (code_b !== load_q[4]) begin
            bad++; $display("[TB] FAIL big_pc4: got %h want %h", code_b, load_q[4]);
        end
        run_cycle(1, 0, 2'd3, 8'd0);
        total++;
        if (code_s !== 9'h000 || valid_s !== 1'b1) begin
            bad++; $display("[TB] FAIL small_oor_bank: got %h/%b want 000/1", code_s, valid_s);
        end
        run_cycle(1, 0, 2'd1, 8'd0);
        total++;
        if (fault_s !== 1'b1 || code_s !== load_q[0]) begin
            bad++; $display("[TB] FAIL fault_sticky: got %b/%h want 1/%h", fault_s, code_s, load_q[0]);
        end
    endtask

    task automatic test_async_reset();
        logic [8:0] w0, w1, w_new;
        w0 = 9'($urandom); w1 = 9'($urandom); w_new = 9'($urandom);
        load_bank = 2'd2; load_start = 1;
        tick();
        load_start = 0;
        model_load_start();
        load_we = 1; load_data = w0; tick(); model_write(2, w0);
        load_data = w1; tick(); model_write(2, w1);
        load_we = 0;
        total++;
        if (loading_b !== 1'b1) begin
            bad++; $display("[TB] FAIL mid_load: got loading=%b want 1", loading_b);
        end
        #3;
        reset = 1;
        #1;
        model_reset();
        total++;
        if ({code_b, valid_b, fault_b, loading_b} !== 12'h000 || {code_s, valid_s, fault_s, loading_s} !== 12'h000) begin
            bad++; $display("[TB] FAIL async_reset: got %h %h want 000 000",
                            {code_b, valid_b, fault_b, loading_b}, {code_s, valid_s, fault_s, loading_s});
        end
        #2;
        reset = 0;
        load_q = '{w_new};
        do_load(2'd2);
        run_cycle(1, 0, 2'd2, 8'd0);
        total++;
        if (code_b !== w_new || code_s !== w_new) begin
            bad++; $display("[TB] FAIL reload_addr0: got %h/%h want %h", code_b, code_s, w_new);
        end
        run_cycle(1, 0, 2'd2, 8'd1);
        total++;
        if (code_b !== w1) begin
            bad++; $display("[TB] FAIL ram_kept: got %h want %h", code_b, w1);
        end
    endtask

    task automatic test_start_done();
        logic [8:0] a, b, c;
        a = 9'($urandom); b = 9'($urandom); c = 9'($urandom);
        load_bank = 2'd3; load_start = 1;
        tick();
        load_start = 0;
        model_load_start();
        load_we = 1; load_data = a; tick(); model_write(3, a);
        load_data = b; tick(); model_write(3, b);
        load_we = 0;
        load_start = 1; load_done = 1;
        tick();
        load_start = 0; load_done = 0;
        model_load_start();
        total++;
        if (loading_b !== 1'b1 || loading_s !== 1'b1) begin
            bad++; $display("[TB] FAIL start_wins: got loading=%b/%b want 1/1", loading_b, loading_s);
        end
        load_we = 1; load_data = c; tick(); model_write(3, c);
        load_we = 0; load_done = 1; tick(); load_done = 0;
        run_cycle(1, 0, 2'd3, 8'd0);
        total++;
        if (code_b !== c) begin
            bad++; $display("[TB] FAIL restart_addr0: got %h want %h", code_b, c);
        end
        run_cycle(1, 0, 2'd3, 8'd1);
        total++;
        if (code_b !== b) begin
            bad++; $display("[TB] FAIL restart_addr1: got %h want %h", code_b, b);
        end
    endtask

    task automatic test_random();
        for (int bk = 0; bk < 4; bk++) begin
            load_q = {};
            for (int i = 0; i < 12; i++) load_q.push_back(9'($urandom));
            do_load(2'(bk));
        end
        for (int n = 0; n < 60; n++) begin
            run_cycle(($urandom % 4) != 0, ($urandom % 5) == 0, 2'($urandom % 4), 8'($urandom % 16));
            total++;
            if ((e_kb && code_b !== e_code_b) || valid_b !== e_valid || fault_b !== f_b) begin
                bad++; $display("[TB] FAIL rand_big%0d: got %h/%b/%b want %h/%b/%b",
                                n, code_b, valid_b, fault_b, e_code_b, e_valid, f_b);
            end
            total++;
            if ((e_ks && code_s !== e_code_s) || valid_s !== e_valid || fault_s !== f_s) begin
                bad++; $display("[TB] FAIL rand_small%0d: got %h/%b/%b want %h/%b/%b",
                                n, code_s, valid_s, fault_s, e_code_s, e_valid, f_s);
            end
        end
    endtask

    initial begin
        reset = 0; bank_sel = '0; prog_ctr = '0; fetch_en = 0; stall = 0;
        load_start = 0; load_bank = '0; load_we = 0; load_data = '0; load_done = 0;
        test_reset();
        test_basic_fetch();
        test_bank_select();
        test_stall();
        test_overflow();
        test_async_reset();
        test_start_done();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
